// File: rtl/fifo_pkg.sv
// Shared constants, types and pointer helpers for the 8-entry FIFO controller.
package fifo_pkg;

    localparam int FIFO_DEPTH   = 8;
    localparam int ADDR_W       = 3;
    localparam int PTR_W        = ADDR_W + 1;
    localparam int CNT_W        = ADDR_W + 1;
    localparam int AF_LEVEL_DEF = 6;
    localparam int AE_LEVEL_DEF = 2;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Occupancy from the two wrap-aware pointers; modulo-16 subtraction
    // gives 0..8 for every legal pointer pair.
    function automatic cnt_t ptr_count(input ptr_t wr_ptr, input ptr_t rd_ptr);
        ptr_t diff;
        diff = wr_ptr - rd_ptr;
        return cnt_t'(diff);
    endfunction

    // Same address with opposite wrap bit means the writer is a full lap ahead.
    function automatic logic ptr_full(input ptr_t wr_ptr, input ptr_t rd_ptr);
        return (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
               (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    endfunction

    function automatic logic ptr_empty(input ptr_t wr_ptr, input ptr_t rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction

endpackage

// File: rtl/fifo_ptr_inc.sv
// Wrap-aware 4-bit FIFO pointer: low bits address the storage, the top bit
// toggles each time the address rolls over from 7 back to 0.
module fifo_ptr_inc
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output ptr_t ptr
);

    // Advance by one (natural modulo-16 roll-over) on each accepted access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ptr_t'(1);
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for the 8-entry FIFO. Drives the 3-to-8 write
// decoder (wr_addr/wr_en), the output-mux read address, occupancy flags and
// the sticky overflow/underflow error flags.
module fifo_ptr_ctrl #(
    // Must stay 3: the downstream decoder is hard-wired 3-to-8.
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [3:0]        count,
    output logic              overflow,
    output logic              underflow
);

    import fifo_pkg::*;

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    logic wr_acc;
    logic rd_acc;

    fifo_ptr_inc u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr_inc u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    // Flags come straight from the registered pointers (pre-edge state).
    always_comb begin
        empty        = ptr_empty(wr_ptr, rd_ptr);
        full         = ptr_full(wr_ptr, rd_ptr);
        count        = ptr_count(wr_ptr, rd_ptr);
        almost_full  = (count >= cnt_t'(AF_LEVEL));
        almost_empty = (count <= cnt_t'(AE_LEVEL));
        wr_addr      = wr_ptr[ADDR_W-1:0];
        rd_addr      = rd_ptr[ADDR_W-1:0];
    end

    // Acceptance is decided on the same cycle as the request. The decoder
    // enable is also held off while reset is asserted so no storage register
    // captures a write during reset, whatever the producer is doing.
    always_comb begin
        wr_acc = wr_req && !full && rst_n;
        rd_acc = rd_req && !empty && rst_n;
        wr_en  = wr_acc;
    end

    // Sticky error flags: a new error in the clear cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: the stimulus process pushes the
// expected response of each cycle from a queue-based FIFO model; a separate
// monitor pops and compares mid-cycle, and also replays storage through the
// DUT addresses to confirm FIFO ordering.
module tb_fifo_ptr_ctrl;

    localparam int AF = 6;
    localparam int AE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] wr_addr;
    logic       wr_en;
    logic [2:0] rd_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(
        .ADDR_W   (3),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .clr_err      (clr_err),
        .wr_addr      (wr_addr),
        .wr_en        (wr_en),
        .rd_addr      (rd_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    typedef struct {
        logic [2:0] wr_addr;
        logic [2:0] rd_addr;
        logic       wr_en;
        logic       rd_acc;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ov;
        logic       un;
        logic [3:0] count;
        int         seq_w;
        int         seq_r;
    } exp_t;

    exp_t sb[$];
    int   q_model[$];
    int   wr_total = 0;
    int   rd_total = 0;
    int   seq_next = 0;
    bit   m_ov = 1'b0;
    bit   m_un = 1'b0;
    int   mem[8];
    int   errors = 0;
    int   checks = 0;
    bit   saw_wrap = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t expect_now(input bit w, input bit r);
        exp_t e;
        int n;
        n = q_model.size();
        if (!rst_n) begin
            e.wr_addr = 3'd0; e.rd_addr = 3'd0; e.wr_en = 1'b0; e.rd_acc = 1'b0;
            e.full = 1'b0; e.empty = 1'b1; e.af = 1'b0; e.ae = 1'b1;
            e.ov = 1'b0; e.un = 1'b0; e.count = 4'd0; e.seq_w = -1; e.seq_r = -1;
        end else begin
            e.count   = 4'(n);
            e.empty   = (n == 0);
            e.full    = (n == 8);
            e.af      = (n >= AF);
            e.ae      = (n <= AE);
            e.wr_en   = w && (n < 8);
            e.rd_acc  = r && (n > 0);
            e.wr_addr = 3'(wr_total % 8);
            e.rd_addr = 3'(rd_total % 8);
            e.ov      = m_ov;
            e.un      = m_un;
            e.seq_w   = seq_next;
            e.seq_r   = (n > 0) ? q_model[0] : -1;
        end
        return e;
    endfunction

    task automatic model_reset();
        q_model.delete();
        wr_total = 0;
        rd_total = 0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic model_step(input exp_t e, input bit w, input bit r, input bit c);
        int n;
        if (!rst_n) return;
        n = q_model.size();
        m_ov = (w && n == 8) ? 1'b1 : (c ? 1'b0 : m_ov);
        m_un = (r && n == 0) ? 1'b1 : (c ? 1'b0 : m_un);
        if (e.rd_acc) begin
            void'(q_model.pop_front());
            rd_total++;
        end
        if (e.wr_en) begin
            q_model.push_back(seq_next);
            seq_next++;
            if (wr_total % 8 == 7) saw_wrap = 1'b1;
            wr_total++;
        end
    endtask

    task automatic cycle(input bit w, input bit r, input bit c);
        exp_t e;
        @(negedge clk);
        wr_req  = w;
        rd_req  = r;
        clr_err = c;
        e = expect_now(w, r);
        sb.push_back(e);
        model_step(e, w, r, c);
    endtask

    // Monitor: compare each cycle's presented outputs against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_en", wr_en, e.wr_en);
                chk("full", full, e.full);
                chk("empty", empty, e.empty);
                chk("count", count, e.count);
                chk("almost_full", almost_full, e.af);
                chk("almost_empty", almost_empty, e.ae);
                chk("overflow", overflow, e.ov);
                chk("underflow", underflow, e.un);
                chk("rd_addr", rd_addr, e.rd_addr);
                if (e.wr_en || !rst_n) chk("wr_addr", wr_addr, e.wr_addr);
                if (e.rd_acc) chk("rd_data_order", mem[rd_addr], e.seq_r);
                if (e.wr_en && wr_en) mem[wr_addr] = e.seq_w;
            end
        end
    end

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        #1;
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        model_reset();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = -1;
        // 1: reset release, idle
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        // 2: fill to full
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        // 3: overflow attempt then clear
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        // 4: simultaneous at full, then write at address 0
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        // drain to empty
        repeat (8) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        // 5: simultaneous at empty
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        // 6: interleaved burst with asynchronous reset in the middle
        for (int i = 0; i < 20; i++) cycle(1'b1, (i % 2) == 1, 1'b0);
        async_reset_check();
        for (int i = 0; i < 20; i++) cycle((i % 3) != 2, 1'b1, 1'b0);
        // random phases biased toward full and toward empty
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 40; i++) begin
                bit w, r, c;
                if (p % 2 == 0) begin
                    w = ($urandom_range(0, 9) < 7);
                    r = ($urandom_range(0, 9) < 3);
                end else begin
                    w = ($urandom_range(0, 9) < 3);
                    r = ($urandom_range(0, 9) < 7);
                end
                c = ($urandom_range(0, 15) == 0);
                cycle(w, r, c);
            end
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #4;
        chk("addr_wrap_seen", saw_wrap, 1);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
